// File: rtl/sdram_chip_model.sv
// Behavioural single-chip SDR SDRAM model: 4 banks, x16 data, burst length 1,
// CAS latency 2 or 3. It also checks the command stream for protocol errors,
// and it records the first error cause in a sticky register.
module sdram_chip_model #(
  parameter int ROW_BITS = 5,
  parameter int RCD_MIN  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_A,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  inout  wire  [15:0] SDRAM_DQ,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_cnt
);

  localparam int ADDR_BITS = 2 + ROW_BITS + 9;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] RCD_SAT = 4'(RCD_MIN);

  // Command encodings on {nRAS, nCAS, nWE} while nCS is low
  localparam logic [2:0] CMD_NOP       = 3'b111;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
  localparam logic [2:0] CMD_BST       = 3'b110;

  localparam logic [2:0] ERR_NOT_READY  = 3'd1;
  localparam logic [2:0] ERR_CLOSED     = 3'd2;
  localparam logic [2:0] ERR_RCD        = 3'd3;
  localparam logic [2:0] ERR_REOPEN     = 3'd4;
  localparam logic [2:0] ERR_REF_OPEN   = 3'd5;
  localparam logic [2:0] ERR_BAD_MODE   = 3'd6;
  localparam logic [2:0] ERR_CONTENTION = 3'd7;

  typedef enum logic [1:0] {
    INIT_WAIT_PRE,
    INIT_WAIT_REF,
    INIT_WAIT_LDM,
    INIT_READY
  } init_state_t;

  init_state_t         state_q, state_d;
  logic                ref_seen_q, ref_seen_d;
  logic [3:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] row_q [4];
  logic [ROW_BITS-1:0] row_d [4];
  logic [3:0]          rcd_cnt_q [4];
  logic [3:0]          rcd_cnt_d [4];
  logic [2:0]          cl_q, cl_d;
  logic [15:0]         refresh_cnt_q, refresh_cnt_d;
  logic                err_q, err_d;
  logic [2:0]          err_code_q, err_code_d;

  // Read pipeline: stage 0 is loaded on the READ edge, the bus is driven
  // from stage CL-1.
  logic [2:0]          rd_valid_q, rd_valid_d;
  logic [2:0]          rd_en_lo_q, rd_en_lo_d;
  logic [2:0]          rd_en_hi_q, rd_en_hi_d;
  logic [15:0]         rd_data_q [3];
  logic [15:0]         rd_data_d [3];

  logic [15:0]         mem_q [DEPTH];

  logic                cmd_sel;
  logic [2:0]          cmd;
  logic [1:0]          bank;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [15:0]         mem_rdata;
  logic                mem_we;
  logic [15:0]         mem_wdata;
  logic                rcd_short;
  logic                mode_ok;
  logic                drv_valid, drv_lo, drv_hi;
  logic [15:0]         drv_data;
  logic                push_valid, push_lo, push_hi;
  logic                flush;
  logic                err_hit;
  logic [2:0]          err_cause;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{SDRAM_A[12:11], SDRAM_A[9]};

  assign cmd       = {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
  assign cmd_sel   = ~SDRAM_nCS;
  assign bank      = SDRAM_BA;
  assign mem_idx   = {bank, row_q[bank], SDRAM_A[8:0]};
  assign mem_rdata = mem_q[mem_idx];
  assign rcd_short = rcd_cnt_q[bank] < RCD_SAT;
  assign mode_ok   = ((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) &&
                     (SDRAM_A[2:0] == 3'd0);

  // Select the pipeline stage whose word is on the bus this cycle
  always_comb begin
    drv_valid = rd_valid_q[1];
    drv_lo    = rd_en_lo_q[1];
    drv_hi    = rd_en_hi_q[1];
    drv_data  = rd_data_q[1];
    if (cl_q == 3'd3) begin
      drv_valid = rd_valid_q[2];
      drv_lo    = rd_en_lo_q[2];
      drv_hi    = rd_en_hi_q[2];
      drv_data  = rd_data_q[2];
    end
  end

  assign SDRAM_DQ[7:0]  = drv_lo ? drv_data[7:0]  : 8'hzz;
  assign SDRAM_DQ[15:8] = drv_hi ? drv_data[15:8] : 8'hzz;

  // Command decode: init FSM, bank state, mode, refresh count, error detect
  always_comb begin
    state_d       = state_q;
    ref_seen_d    = ref_seen_q;
    bank_open_d   = bank_open_q;
    row_d         = row_q;
    rcd_cnt_d     = rcd_cnt_q;
    cl_d          = cl_q;
    refresh_cnt_d = refresh_cnt_q;
    err_hit       = 1'b0;
    err_cause     = 3'd0;
    mem_we        = 1'b0;
    mem_wdata     = mem_rdata;
    push_valid    = 1'b0;
    push_lo       = 1'b0;
    push_hi       = 1'b0;
    flush         = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if (rcd_cnt_q[b] < RCD_SAT) rcd_cnt_d[b] = rcd_cnt_q[b] + 4'd1;
    end

    if (cmd_sel) begin
      case (cmd)
        CMD_ACTIVE: begin
          if (state_q != INIT_READY) begin
            err_hit   = 1'b1;
            err_cause = ERR_NOT_READY;
          end else if (bank_open_q[bank]) begin
            err_hit   = 1'b1;
            err_cause = ERR_REOPEN;
          end else begin
            bank_open_d[bank] = 1'b1;
            row_d[bank]       = SDRAM_A[ROW_BITS-1:0];
            rcd_cnt_d[bank]   = 4'd1;
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (state_q != INIT_READY) begin
            err_hit   = 1'b1;
            err_cause = ERR_NOT_READY;
          end else if (!bank_open_q[bank]) begin
            err_hit   = 1'b1;
            err_cause = ERR_CLOSED;
          end else begin
            if (rcd_short) begin
              err_hit   = 1'b1;
              err_cause = ERR_RCD;
            end else if ((cmd == CMD_WRITE) && drv_valid) begin
              err_hit   = 1'b1;
              err_cause = ERR_CONTENTION;
            end
            if (cmd == CMD_WRITE) begin
              mem_we = 1'b1;
              mem_wdata[7:0]  = SDRAM_DQML ? mem_rdata[7:0]  : SDRAM_DQ[7:0];
              mem_wdata[15:8] = SDRAM_DQMH ? mem_rdata[15:8] : SDRAM_DQ[15:8];
            end else begin
              push_valid = 1'b1;
              push_lo    = ~SDRAM_DQML;
              push_hi    = ~SDRAM_DQMH;
            end
            if (SDRAM_A[10]) bank_open_d[bank] = 1'b0;
          end
        end
        CMD_PRECHARGE: begin
          if (SDRAM_A[10]) begin
            bank_open_d = 4'b0000;
            if (state_q == INIT_WAIT_PRE) state_d = INIT_WAIT_REF;
          end else begin
            bank_open_d[bank] = 1'b0;
          end
        end
        CMD_REFRESH: begin
          if (|bank_open_q) begin
            err_hit   = 1'b1;
            err_cause = ERR_REF_OPEN;
          end
          if (refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
          if (state_q == INIT_WAIT_REF) begin
            if (ref_seen_q) state_d = INIT_WAIT_LDM;
            else            ref_seen_d = 1'b1;
          end
        end
        CMD_LOAD_MODE: begin
          if (mode_ok) begin
            cl_d = SDRAM_A[6:4];
          end else begin
            err_hit   = 1'b1;
            err_cause = ERR_BAD_MODE;
          end
          if (state_q == INIT_WAIT_LDM) state_d = INIT_READY;
        end
        CMD_BST: flush = 1'b1;
        CMD_NOP: ;
        default: ;
      endcase
    end

    err_d      = err_q;
    err_code_d = err_code_q;
    if (err_hit && !err_q) begin
      err_d      = 1'b1;
      err_code_d = err_cause;
    end
  end

  // Read pipeline shift, loading a new word on READ and emptying on BURST_TERMINATE
  always_comb begin
    rd_valid_d   = {rd_valid_q[1:0], push_valid};
    rd_en_lo_d   = {rd_en_lo_q[1:0], push_lo};
    rd_en_hi_d   = {rd_en_hi_q[1:0], push_hi};
    rd_data_d[0] = mem_rdata;
    rd_data_d[1] = rd_data_q[0];
    rd_data_d[2] = rd_data_q[1];
    if (flush) begin
      rd_valid_d = 3'b000;
      rd_en_lo_d = 3'b000;
      rd_en_hi_d = 3'b000;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT_WAIT_PRE;
      ref_seen_q    <= 1'b0;
      bank_open_q   <= 4'b0000;
      cl_q          <= 3'd2;
      refresh_cnt_q <= 16'd0;
      err_q         <= 1'b0;
      err_code_q    <= 3'd0;
      rd_valid_q    <= 3'b000;
      rd_en_lo_q    <= 3'b000;
      rd_en_hi_q    <= 3'b000;
      for (int b = 0; b < 4; b++) begin
        row_q[b]     <= '0;
        rcd_cnt_q[b] <= RCD_SAT;
      end
      for (int s = 0; s < 3; s++) rd_data_q[s] <= 16'd0;
    end else begin
      state_q       <= state_d;
      ref_seen_q    <= ref_seen_d;
      bank_open_q   <= bank_open_d;
      row_q         <= row_d;
      rcd_cnt_q     <= rcd_cnt_d;
      cl_q          <= cl_d;
      refresh_cnt_q <= refresh_cnt_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      rd_valid_q    <= rd_valid_d;
      rd_en_lo_q    <= rd_en_lo_d;
      rd_en_hi_q    <= rd_en_hi_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Backing store write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_idx] <= mem_wdata;
  end

  assign init_done   = (state_q == INIT_READY);
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign refresh_cnt = refresh_cnt_q;

endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed bench for sdram_chip_model: table of single-cycle commands with
// expected outputs, then hand-written multi-cycle sequences. The data bus
// is pulled up, so an undriven byte reads back as 8'hFF.
module tb_sdram_chip_model;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_BST = 4'b0110;
  localparam logic [15:0] HIZ  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nCS = 1'b0, nRAS = 1'b1, nCAS = 1'b1, nWE = 1'b1;
  logic [1:0]  BA = 2'd0;
  logic [12:0] A = 13'd0;
  logic        DQML = 1'b0, DQMH = 1'b0;
  wire  [15:0] SDRAM_DQ;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dq = 16'd0;
  logic        init_done, err;
  logic [2:0]  err_code;
  logic [15:0] refresh_cnt;

  int checks = 0;
  int errors = 0;

  assign SDRAM_DQ = tb_drv ? tb_dq : 16'hzzzz;
  pullup (SDRAM_DQ);

  always #5 clk = ~clk;

  sdram_chip_model #(.ROW_BITS(5), .RCD_MIN(2)) dut (
    .clk(clk), .reset(reset),
    .SDRAM_nCS(nCS), .SDRAM_nRAS(nRAS), .SDRAM_nCAS(nCAS), .SDRAM_nWE(nWE),
    .SDRAM_BA(BA), .SDRAM_A(A), .SDRAM_DQML(DQML), .SDRAM_DQMH(DQMH),
    .SDRAM_DQ(SDRAM_DQ),
    .init_done(init_done), .err(err), .err_code(err_code), .refresh_cnt(refresh_cnt)
  );

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        ml, mh, drv;
    logic [15:0] dq;
    logic [15:0] exp_dq;
    logic        exp_init, exp_err;
    logic [2:0]  exp_code;
    logic [15:0] exp_ref;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic [3:0] cmd, logic [1:0] ba, logic [12:0] a,
                              logic ml, logic mh, logic drv, logic [15:0] dq,
                              logic [15:0] exp_dq, logic exp_init, logic exp_err,
                              logic [2:0] exp_code, logic [15:0] exp_ref);
    vec_t v;
    v.name = name; v.cmd = cmd; v.ba = ba; v.a = a; v.ml = ml; v.mh = mh;
    v.drv = drv; v.dq = dq; v.exp_dq = exp_dq; v.exp_init = exp_init;
    v.exp_err = exp_err; v.exp_code = exp_code; v.exp_ref = exp_ref;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present one command across a rising edge, return to NOP, wait for the falling edge
  task automatic drive(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] a,
                       input logic ml, input logic mh, input logic drv, input logic [15:0] dq);
    {nCS, nRAS, nCAS, nWE} = cmd;
    BA = ba; A = a; DQML = ml; DQMH = mh; tb_drv = drv; tb_dq = dq;
    @(posedge clk);
    #1;
    {nCS, nRAS, nCAS, nWE} = C_NOP;
    DQML = 1'b0; DQMH = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
  endtask

  task automatic nop();
    drive(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.cmd, v.ba, v.a, v.ml, v.mh, v.drv, v.dq);
    checkOutput({v.name, ".dq"},   SDRAM_DQ, v.exp_dq);
    checkOutput({v.name, ".init"}, {15'd0, init_done}, {15'd0, v.exp_init});
    checkOutput({v.name, ".err"},  {15'd0, err}, {15'd0, v.exp_err});
    checkOutput({v.name, ".code"}, {13'd0, err_code}, {13'd0, v.exp_code});
    checkOutput({v.name, ".ref"},  refresh_cnt, v.exp_ref);
  endtask

  task automatic doReset();
    reset = 1'b1;
    nop();
    nop();
    reset = 1'b0;
  endtask

  task automatic doInit(input logic [12:0] lmr_a);
    drive(C_PRE, 2'd0, 13'h400, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_LMR, 2'd0, lmr_a,   1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    //              name             cmd    ba    a        ml mh drv dq         exp_dq    init err code ref
    tbl.push_back(mk("pre_all",      C_PRE, 2'd0, 13'h400, 0, 0, 0, 16'h0000, HIZ,      0, 0, 3'd0, 16'd0));
    tbl.push_back(mk("ref1",         C_REF, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      0, 0, 3'd0, 16'd1));
    tbl.push_back(mk("ref2",         C_REF, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      0, 0, 3'd0, 16'd2));
    tbl.push_back(mk("lmr_cl2",      C_LMR, 2'd0, 13'h220, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("act_b1",       C_ACT, 2'd1, 13'h003, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("gap1",         C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("wr_beef_ap",   C_WR,  2'd1, 13'h405, 0, 0, 1, 16'hBEEF, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("act_b1_again", C_ACT, 2'd1, 13'h003, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("gap2",         C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_beef_e0",   C_RD,  2'd1, 13'h405, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_beef_e1",   C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, 16'hBEEF, 1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_beef_e2",   C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("act_closed_ok",C_ACT, 2'd1, 13'h003, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("gap3",         C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("wr_1234",      C_WR,  2'd1, 13'h006, 0, 0, 1, 16'h1234, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("wr_abcd_mh",   C_WR,  2'd1, 13'h006, 0, 1, 1, 16'hABCD, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_mask_e0",   C_RD,  2'd1, 13'h006, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_mask_e1",   C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, 16'h12CD, 1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_mask_e2",   C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_dqml_e0",   C_RD,  2'd1, 13'h006, 1, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_dqml_e1",   C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, 16'h12FF, 1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("rd_dqml_e2",   C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("wr_5a5a",      C_WR,  2'd1, 13'h007, 0, 0, 1, 16'h5A5A, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("b2b_rd1",      C_RD,  2'd1, 13'h006, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("b2b_rd2",      C_RD,  2'd1, 13'h007, 0, 0, 0, 16'h0000, 16'h12CD, 1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("b2b_data2",    C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, 16'h5A5A, 1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("b2b_idle",     C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("bst_rd",       C_RD,  2'd1, 13'h007, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("bst_cancel",   C_BST, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("bst_idle",     C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("cont_rd",      C_RD,  2'd1, 13'h006, 0, 0, 0, 16'h0000, HIZ,      1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("cont_e1",      C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, 16'h12CD, 1, 0, 3'd0, 16'd2));
    tbl.push_back(mk("cont_wr",      C_WR,  2'd1, 13'h00F, 1, 1, 0, 16'h0000, HIZ,      1, 1, 3'd7, 16'd2));
    tbl.push_back(mk("cont_sticky",  C_NOP, 2'd0, 13'h000, 0, 0, 0, 16'h0000, HIZ,      1, 1, 3'd7, 16'd2));

    @(negedge clk);
    doReset();
    checkOutput("rst.dq",   SDRAM_DQ, HIZ);
    checkOutput("rst.init", {15'd0, init_done}, 16'd0);
    checkOutput("rst.err",  {15'd0, err}, 16'd0);
    checkOutput("rst.code", {13'd0, err_code}, 16'd0);
    checkOutput("rst.ref",  refresh_cnt, 16'd0);

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Reset sampled at E1 of a CL=2 read: the word must never appear
    drive(C_RD, 2'd1, 13'h405, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    nop();
    checkOutput("rstmid.dq_e1", SDRAM_DQ, HIZ);
    checkOutput("rstmid.init",  {15'd0, init_done}, 16'd0);
    checkOutput("rstmid.err",   {15'd0, err}, 16'd0);
    checkOutput("rstmid.code",  {13'd0, err_code}, 16'd0);
    checkOutput("rstmid.ref",   refresh_cnt, 16'd0);
    nop();
    reset = 1'b0;
    checkOutput("rstmid.dq_e2", SDRAM_DQ, HIZ);
    doInit(13'h220);
    checkOutput("reinit.init", {15'd0, init_done}, 16'd1);
    drive(C_ACT, 2'd1, 13'h003, 1'b0, 1'b0, 1'b0, 16'd0);
    nop();
    drive(C_RD, 2'd1, 13'h006, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_RD, 2'd1, 13'h405, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("intact.12cd", SDRAM_DQ, 16'h12CD);
    nop();
    checkOutput("intact.beef", SDRAM_DQ, 16'hBEEF);
    nop();
    checkOutput("intact.idle", SDRAM_DQ, HIZ);
    checkOutput("intact.err",  {15'd0, err}, 16'd0);

    // CAS latency 3, then an illegal mode that must leave CL at 3
    drive(C_LMR, 2'd0, 13'h230, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("cl3.err", {15'd0, err}, 16'd0);
    drive(C_ACT, 2'd1, 13'h003, 1'b0, 1'b0, 1'b0, 16'd0);
    nop();
    drive(C_RD, 2'd1, 13'h405, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("cl3.e0", SDRAM_DQ, HIZ);
    nop();
    checkOutput("cl3.e1", SDRAM_DQ, HIZ);
    nop();
    checkOutput("cl3.e2", SDRAM_DQ, 16'hBEEF);
    nop();
    checkOutput("cl3.e3", SDRAM_DQ, HIZ);
    drive(C_LMR, 2'd0, 13'h250, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("badmode.err",  {15'd0, err}, 16'd1);
    checkOutput("badmode.code", {13'd0, err_code}, 16'd6);
    drive(C_ACT, 2'd1, 13'h003, 1'b0, 1'b0, 1'b0, 16'd0);
    nop();
    drive(C_RD, 2'd1, 13'h006, 1'b0, 1'b0, 1'b0, 16'd0);
    nop();
    checkOutput("keepcl3.e1", SDRAM_DQ, HIZ);
    nop();
    checkOutput("keepcl3.e2", SDRAM_DQ, 16'h12CD);
    nop();
    checkOutput("keepcl3.e3", SDRAM_DQ, HIZ);

    // READ before init completes
    doReset();
    drive(C_RD, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("notready.code", {13'd0, err_code}, 16'd1);

    // READ to a closed bank has no bus effect
    doReset();
    doInit(13'h220);
    drive(C_RD, 2'd2, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("closed.code", {13'd0, err_code}, 16'd2);
    nop();
    checkOutput("closed.dq", SDRAM_DQ, HIZ);

    // READ one cycle after ACTIVE still returns data
    doReset();
    doInit(13'h220);
    drive(C_ACT, 2'd1, 13'h003, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_RD, 2'd1, 13'h405, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("rcd.code", {13'd0, err_code}, 16'd3);
    nop();
    checkOutput("rcd.dq", SDRAM_DQ, 16'hBEEF);

    // ACTIVE to an already open bank
    doReset();
    doInit(13'h220);
    drive(C_ACT, 2'd0, 13'h001, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_ACT, 2'd0, 13'h002, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("reopen.code", {13'd0, err_code}, 16'd4);

    // AUTO_REFRESH with a bank open still counts
    doReset();
    doInit(13'h220);
    drive(C_ACT, 2'd0, 13'h001, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(C_REF, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("refopen.code", {13'd0, err_code}, 16'd5);
    checkOutput("refopen.ref",  refresh_cnt, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
